reg_writeback_queue: RTL and testbench

- Write-side producer for the 32x64 register file: buffers results from the execute/memory stages and drives the file's RegWrite/WriteRegister/WriteData port, one write per cycle.
- Tells decode which source registers still have a write pending (scoreboard), so decode can stall.
- Sits between the memory stage and the register file in the single-cycle-to-pipelined CPU.
- Register 31 (XZR) is never written.

---
 rtl/reg_writeback_queue_pkg.sv | 14 +
 rtl/reg_writeback_queue_wb_match.sv | 45 ++++
 rtl/reg_writeback_queue.sv | 93 +++++++++
 tb/tb_reg_writeback_queue.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/reg_writeback_queue_pkg.sv
// Shared types and constants for the register write-back queue.
package regwb_pkg;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;
  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/reg_writeback_queue_wb_match.sv
// Per-read-port lookup over the queued writes: any-hit plus youngest-hit data.
// Youngest-hit data path exists only when REGWB_FORWARDING_EN is defined.
module wb_match
  import regwb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  wb_entry_t         entries [DEPTH],
  input  logic [PW-1:0]     head,
  input  logic [CW-1:0]     count,
  input  logic [ADDR_W-1:0] readReg,
  output logic              hit,
  output logic [DATA_W-1:0] data
);

  logic [PW-1:0] idx;

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if ((CW'(i) < count) && entries[idx].valid &&
          (entries[idx].rd == readReg) && (readReg != ZERO_REG)) begin
        hit = 1'b1;
`ifdef REGWB_FORWARDING_EN
        data = entries[idx].data;
`endif
      end
    end
  end

`ifndef REGWB_FORWARDING_EN
  logic unusedData;
  always_comb begin
    unusedData = 1'b0;
    for (int i = 0; i < DEPTH; i++) unusedData = unusedData ^ (^entries[i].data);
  end
`endif

endmodule

// File: rtl/reg_writeback_queue.sv
// Write-back queue feeding the 32x64 register file, with decode hazard lookup.
// Optional bypass data on fwd_* ports when REGWB_FORWARDING_EN is defined.
module reg_writeback_queue
  import regwb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_reg,
  input  logic [DATA_W-1:0] in_data,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteRegister,
  output logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  output logic              hazard1,
  output logic              hazard2,
  output logic [CW-1:0]     count,
  output logic              fwd_valid1,
  output logic              fwd_valid2,
  output logic [DATA_W-1:0] fwd_data1,
  output logic [DATA_W-1:0] fwd_data2
);

  wb_entry_t     entries [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic          push;
  logic          pop;
  logic          hit1;
  logic          hit2;
  logic [DATA_W-1:0] matchData1;
  logic [DATA_W-1:0] matchData2;

  // Handshake: a transfer happens on the edge where in_valid && in_ready; in_ready
  // depends only on count, and XZR results complete the handshake but are dropped.
  assign in_ready = (count != CW'(DEPTH));
  assign push     = in_valid && in_ready && (in_reg != ZERO_REG);
  // Gated by reset so a flush never lets a pending entry reach the register file.
  assign pop      = (count != '0) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i].valid <= 1'b0;
    end else begin
      if (pop) begin
        entries[head].valid <= 1'b0;
        head <= head + 1'b1;
      end
      if (push) begin
        entries[tail] <= '{valid: 1'b1, rd: in_reg, data: in_data};
        tail <= tail + 1'b1;
      end
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  assign RegWrite      = pop;
  assign WriteRegister = pop ? entries[head].rd   : ZERO_REG;
  assign WriteData     = pop ? entries[head].data : '0;

  wb_match #(.DEPTH(DEPTH)) u_match1 (
    .entries(entries), .head(head), .count(count),
    .readReg(ReadRegister1), .hit(hit1), .data(matchData1)
  );

  wb_match #(.DEPTH(DEPTH)) u_match2 (
    .entries(entries), .head(head), .count(count),
    .readReg(ReadRegister2), .hit(hit2), .data(matchData2)
  );

  assign hazard1   = hit1;
  assign hazard2   = hit2;
  assign fwd_data1 = matchData1;
  assign fwd_data2 = matchData2;
`ifdef REGWB_FORWARDING_EN
  assign fwd_valid1 = hit1;
  assign fwd_valid2 = hit2;
`else
  assign fwd_valid1 = 1'b0;
  assign fwd_valid2 = 1'b0;
`endif

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Bench for reg_writeback_queue: directed scenarios plus random traffic against a queue model.
module tb_reg_writeback_queue;
  import regwb_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH) + 1;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_reg;
  logic [DATA_W-1:0] in_data;
  logic              RegWrite;
  logic [ADDR_W-1:0] WriteRegister;
  logic [DATA_W-1:0] WriteData;
  logic [ADDR_W-1:0] ReadRegister1;
  logic [ADDR_W-1:0] ReadRegister2;
  logic              hazard1;
  logic              hazard2;
  logic [CW-1:0]     count;
  logic              fwd_valid1;
  logic              fwd_valid2;
  logic [DATA_W-1:0] fwd_data1;
  logic [DATA_W-1:0] fwd_data2;

  reg_writeback_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_data(in_data),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .hazard1(hazard1), .hazard2(hazard2), .count(count),
    .fwd_valid1(fwd_valid1), .fwd_valid2(fwd_valid2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
  );

  // scoreboard: pending writes as {reg, data}, oldest first
  logic [68:0] exp_q[$];
  logic [63:0] modelRf[32];
  logic [63:0] dutRf[32];
  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // shadow of the register file as written by the DUT
  always @(posedge clk) if (RegWrite === 1'b1) dutRf[WriteRegister] <= WriteData;

  function automatic bit model_hit(input logic [4:0] rr);
    if (rr == 5'd31) return 1'b0;
    foreach (exp_q[i]) if (exp_q[i][68:64] == rr) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [63:0] model_fwd(input logic [4:0] rr);
    if (rr == 5'd31) return 64'd0;
    for (int i = exp_q.size() - 1; i >= 0; i--)
      if (exp_q[i][68:64] == rr) return exp_q[i][63:0];
    return 64'd0;
  endfunction

  // driver: apply one cycle of inputs, check outputs mid-cycle, then advance model at the edge
  task automatic do_cycle(input logic v, input logic [4:0] r, input logic [63:0] d,
                          input logic [4:0] rr1, input logic [4:0] rr2);
    bit accept;
    logic [68:0] e;
    in_valid = v; in_reg = r; in_data = d;
    ReadRegister1 = rr1; ReadRegister2 = rr2;
    #2;
    check_val("count", 64'(count), 64'(exp_q.size()));
    check_val("in_ready", 64'(in_ready), 64'(exp_q.size() != DEPTH));
    check_val("RegWrite", 64'(RegWrite), 64'(exp_q.size() > 0));
    check_val("WriteRegister", 64'(WriteRegister), exp_q.size() > 0 ? 64'(exp_q[0][68:64]) : 64'd31);
    check_val("WriteData", WriteData, exp_q.size() > 0 ? exp_q[0][63:0] : 64'd0);
    check_val("hazard1", 64'(hazard1), 64'(model_hit(rr1)));
    check_val("hazard2", 64'(hazard2), 64'(model_hit(rr2)));
`ifdef REGWB_FORWARDING_EN
    check_val("fwd_valid1", 64'(fwd_valid1), 64'(model_hit(rr1)));
    check_val("fwd_valid2", 64'(fwd_valid2), 64'(model_hit(rr2)));
    check_val("fwd_data1", fwd_data1, model_fwd(rr1));
    check_val("fwd_data2", fwd_data2, model_fwd(rr2));
`else
    check_val("fwd_valid1", 64'(fwd_valid1), 64'd0);
    check_val("fwd_valid2", 64'(fwd_valid2), 64'd0);
    check_val("fwd_data1", fwd_data1, 64'd0);
    check_val("fwd_data2", fwd_data2, 64'd0);
`endif
    accept = v && (exp_q.size() != DEPTH) && (r != 5'd31);
    @(posedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      modelRf[e[68:64]] = e[63:0];
    end
    if (accept) exp_q.push_back({r, d});
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    #2;
    check_val("rst_nowrite", 64'(RegWrite), 64'd0);
    @(posedge clk);
    exp_q.delete();
    #1;
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, 5'd0, 64'd0, 5'd0, 5'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      modelRf[i] = 64'd0;
      dutRf[i] = 64'd0;
    end
    reset = 1'b1; in_valid = 1'b0; in_reg = '0; in_data = '0;
    ReadRegister1 = '0; ReadRegister2 = '0;
    do_reset();

    // single push, then its write, then empty
    do_cycle(1'b1, 5'd5, 64'hDEAD_BEEF, 5'd5, 5'd0);
    do_cycle(1'b0, 5'd0, 64'd0, 5'd5, 5'd0);
    do_cycle(1'b0, 5'd0, 64'd0, 5'd5, 5'd0);
    check_val("rf5", dutRf[5], 64'hDEAD_BEEF);

    // back-to-back pushes drain in order
    for (int r = 1; r <= 4; r++) do_cycle(1'b1, 5'(r), 64'(100 + r), 5'(r), 5'(r - 1));
    for (int r = 5; r <= 9; r++) do_cycle(1'b1, 5'(r), 64'(200 + r), 5'(r - 1), 5'(r));
    idle(2);

    // XZR result: handshake only
    do_cycle(1'b1, 5'd31, 64'd1, 5'd31, 5'd31);
    do_cycle(1'b0, 5'd0, 64'd0, 5'd31, 5'd31);

    // duplicate destination, youngest value lands
    do_cycle(1'b1, 5'd7, 64'd10, 5'd0, 5'd7);
    do_cycle(1'b1, 5'd7, 64'd20, 5'd0, 5'd7);
    do_cycle(1'b0, 5'd0, 64'd0, 5'd0, 5'd7);
    idle(1);
    check_val("rf7", dutRf[7], 64'd20);

    // reset with a pending entry: it must never be written
    do_cycle(1'b1, 5'd12, 64'd11, 5'd0, 5'd0);
    do_cycle(1'b1, 5'd13, 64'd12, 5'd0, 5'd0);
    do_reset();
    idle(2);
    check_val("discard13", dutRf[13], 64'd0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      do_cycle(1'($urandom_range(0, 3) != 0),
               5'($urandom_range(0, 31)),
               {32'($urandom), 32'($urandom)},
               5'($urandom_range(0, 31)),
               5'($urandom_range(0, 31)));
      if ($urandom_range(0, 99) == 0) do_reset();
    end
    idle(3);

    for (int i = 0; i < 32; i++) check_val($sformatf("rf%0d", i), dutRf[i], modelRf[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
